// File: rtl/thermometer_pkg.sv
// Shared definitions for the thermometer encoder/decoder/checker family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package thermometer_pkg;

    // Default sizing shared by thermometer_encoder, thermometer_decoder and
    // thermometer_serial_checker.
    localparam int K_DEF  = 5;
    localparam int W_DEF  = 2**K_DEF - 1;
    localparam int EW_DEF = 8;

    // Checker FSM encoding. ST_ILLEGAL can only be reached via an upset and
    // is steered back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

endpackage

// File: rtl/thermometer_serial_checker_bit_scanner.sv
// Serial thermometer-code scanner datapath: examines one bit per step, LSB first.
// Latency: W steps after load; done pulses on the step that examines bit W-1.
// Backpressure: none; the controller decides when to load and step.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   load, code      capture a new code and clear the accumulators
//   step            examine shreg[0], then shift right
//   done            high during the step that examines bit W-1
//   ones_next       ones count including the bit examined this cycle
//   error_next      bubble flag including the bit examined this cycle
module thermometer_bit_scanner
    import thermometer_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int W = 2**K - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] code,
    output logic         done,
    output logic [K-1:0] ones_next,
    output logic         error_next
);

    logic [W-1:0] shreg;
    logic [K-1:0] bit_idx;
    logic [K-1:0] ones;
    logic         seen_zero;
    logic         error;

    logic cur_bit;
    assign cur_bit = shreg[0];

    // A 1 before any 0 extends the run; a 1 after a 0 is a bubble and
    // leaves the count untouched.
    always_comb begin
        ones_next  = ones;
        error_next = error;
        if (cur_bit && !seen_zero) begin
            ones_next = ones + K'(1);
        end
        if (cur_bit && seen_zero) begin
            error_next = 1'b1;
        end
    end

    assign done = step && (bit_idx == K'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            bit_idx   <= '0;
            ones      <= '0;
            seen_zero <= 1'b0;
            error     <= 1'b0;
        end else if (load) begin
            shreg     <= code;
            bit_idx   <= '0;
            ones      <= '0;
            seen_zero <= 1'b0;
            error     <= 1'b0;
        end else if (step) begin
            shreg     <= {1'b0, shreg[W-1:1]};
            bit_idx   <= done ? '0 : bit_idx + K'(1);
            ones      <= ones_next;
            error     <= error_next;
            if (!cur_bit) begin
                seen_zero <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/thermometer_serial_checker.sv
// Sequential thermometer-code checker: decodes leading ones, flags bubbles, counts malformed codes.
// Latency: code accepted at edge t, result valid after W more edges (one SCAN cycle per bit).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     input handshake, in_code sampled on acceptance only
//   out_valid/out_ready   output handshake, out_value/out_error stable while valid
//   err_count             saturating count of codes that contained a bubble
module thermometer_serial_checker
    import thermometer_pkg::*;
#(
    parameter int K  = K_DEF,
    parameter int W  = 2**K - 1,
    parameter int EW = EW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_code,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_value,
    output logic          out_error,
    output logic [EW-1:0] err_count
);

    state_t state;
    state_t state_next;

    logic         load;
    logic         step;
    logic         scan_done;
    logic [K-1:0] ones_next;
    logic         error_next;

    assign load = (state == ST_IDLE) && in_valid;
    assign step = (state == ST_SCAN);

    thermometer_bit_scanner #(
        .K (K),
        .W (W)
    ) u_scanner (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (step),
        .code       (in_code),
        .done       (scan_done),
        .ones_next  (ones_next),
        .error_next (error_next)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_value <= '0;
            out_error <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_next;
            // Capture the result including the final bit examined this cycle.
            if (state == ST_SCAN && scan_done) begin
                out_value <= ones_next;
                out_error <= error_next;
                if (error_next && (err_count != {EW{1'b1}})) begin
                    err_count <= err_count + EW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_thermometer_serial_checker.sv
module tb_thermometer_serial_checker;

    localparam int K  = 5;
    localparam int W  = 31;
    localparam int EW = 8;

    typedef struct packed {
        logic [K-1:0]  value;
        logic          error;
        logic [EW-1:0] count;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_code;
    logic          out_valid;
    logic          out_ready;
    logic [K-1:0]  out_value;
    logic          out_error;
    logic [EW-1:0] err_count;

    thermometer_serial_checker #(.K(K), .W(W), .EW(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_error (out_error),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   chk_timing = 1'b0;
    int   low_run = 0;
    int   exp_cnt = 0;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Thermometer encoding of a: the lowest a bits set.
    function automatic logic [W-1:0] therm(input int a);
        logic [W:0] one;
        one = (W+1)'(1);
        return W'((one << a) - (W+1)'(1));
    endfunction

    // Monitor: samples just after the falling edge, when driven inputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                low_run = 0;
            end else begin
                if (!in_ready) begin
                    low_run++;
                end else begin
                    if (chk_timing && low_run > 0) check("in_ready_low_cycles", low_run, W + 1);
                    low_run = 0;
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("out_value", int'(out_value), int'(e.value));
                        check("out_error", int'(out_error), int'(e.error));
                        check("err_count", int'(err_count), int'(e.count));
                        // Counted from the handshake cycle to the first valid cycle.
                        if (chk_timing) check("latency", cyc - acc_cyc, W + 1);
                    end
                end
            end
        end
    end

    // Called at a falling edge; returns at a falling edge after acceptance.
    task automatic send(input logic [W-1:0] code, input int ev, input bit ee);
        int n = 0;
        exp_t e;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            in_valid = 1'b1;
            in_code  = code;
            acc_cyc  = cyc;
            if (ee) exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
            e.value = K'(ev);
            e.error = ee;
            e.count = EW'(exp_cnt);
            q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
            in_code  = W'($urandom);  // must be ignored while scanning
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_value", int'(out_value), 0);
        check("rst_out_error", int'(out_error), 0);
        check("rst_err_count", int'(err_count), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic code with latency and occupancy timing.
        chk_timing = 1'b1;
        send(W'(32'h0000_0007), 3, 1'b0);
        drain();

        // Every encoder output 0..31, back to back.
        for (int a = 0; a <= W; a++) send(therm(a), a, 1'b0);
        drain();
        chk_timing = 1'b0;

        // Boundary: bit 0 clear with higher bits set.
        send(W'(32'h7FFF_FFFE), 0, 1'b1);
        // Bubble at bit 4.
        send(W'(32'h0000_002F), 4, 1'b1);
        drain();
        check("err_count_after_bubbles", int'(err_count), 2);

        // Hold the result in DONE while a new code waits.
        out_ready = 1'b0;
        send(W'(32'h0000_0007), 3, 1'b0);
        begin
            int n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("hold_reached_done", int'(out_valid), 1);
        end
        in_valid = 1'b1;
        in_code  = W'(32'h0000_001F);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_out_value", int'(out_value), 3);
            check("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        begin
            exp_t e;
            e.value = K'(5);
            e.error = 1'b0;
            e.count = EW'(exp_cnt);
            q.push_back(e);
        end
        @(negedge clk);
        check("release_out_valid", int'(out_valid), 0);
        check("release_in_ready", int'(in_ready), 1);
        @(negedge clk);
        check("accepted_next_cycle", int'(in_ready), 0);
        in_valid = 1'b0;
        drain();

        // Saturation of the malformed-code counter.
        for (int i = 0; i < 300; i++) send(W'(32'h0000_0002), 0, 1'b1);
        drain();
        check("err_count_saturated", int'(err_count), 255);

        // Reset in the middle of a scan discards the result.
        send(W'(32'h0000_0007), 3, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_cnt = 0;
        check("midscan_rst_in_ready", int'(in_ready), 1);
        check("midscan_rst_out_valid", int'(out_valid), 0);
        check("midscan_rst_err_count", int'(err_count), 0);
        send(W'(32'h7FFF_FFFF), 31, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
